// File: rtl/deser32b_align.sv
// deser32b_align: 32:1 MSB-first deserializer that finds the word boundary
// from a repeated sync word, verifies it, then emits aligned parallel words.
module deser32b_align #(
  parameter logic [31:0] SYNC_WORD = 32'hF0F0_A5A5,
  parameter int unsigned LOCK_CNT  = 4
) (
  input  logic        CLKBit,
  input  logic        RSTn,
  input  logic        SerIn,
  input  logic        ReSync,
  output logic [31:0] DataOut,
  output logic        DataValid,
  output logic        CLKWord,
  output logic        Locked,
  output logic [7:0]  ResyncCount
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  localparam logic [3:0] LOCK_CNT_V = 4'(LOCK_CNT);

  // Only 31 history bits are kept: the oldest bit of a 32-bit shifter would
  // never be observed, since the window always includes the current SerIn.
  logic [30:0] sr;
  logic [31:0] win;
  logic [5:0]  fill;
  logic [4:0]  cnt;
  logic [3:0]  mc;
  state_t      state;
  logic        sync_hit;
  logic        boundary;
  logic        search_armed;
  logic [7:0]  resync_inc;

  assign win          = {sr, SerIn};
  assign sync_hit     = (win == SYNC_WORD);
  assign boundary     = (cnt == 5'd0);
  assign search_armed = (fill >= 6'd31);
  assign CLKWord      = cnt[4];
  assign resync_inc   = (ResyncCount == 8'hFF) ? ResyncCount : ResyncCount + 8'd1;

  // Shifter, counters and alignment FSM with registered outputs.
  always_ff @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn) begin
      sr          <= '0;
      cnt         <= 5'd31;
      fill        <= '0;
      mc          <= '0;
      state       <= SEARCH;
      DataOut     <= '0;
      DataValid   <= 1'b0;
      Locked      <= 1'b0;
      ResyncCount <= '0;
    end else begin
      sr        <= win[30:0];
      cnt       <= cnt - 5'd1;
      fill      <= (fill == 6'd32) ? fill : fill + 6'd1;
      DataValid <= 1'b0;
      if (ReSync) begin
        state       <= SEARCH;
        mc          <= '0;
        fill        <= '0;
        Locked      <= 1'b0;
        ResyncCount <= resync_inc;
      end else begin
        case (state)
          SEARCH: begin
            if (search_armed && sync_hit) begin
              cnt <= 5'd31;
              mc  <= 4'd1;
              if (LOCK_CNT_V == 4'd1) begin
                state  <= LOCKED;
                Locked <= 1'b1;
              end else begin
                state <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (boundary) begin
              if (sync_hit) begin
                mc <= mc + 4'd1;
                if (mc + 4'd1 == LOCK_CNT_V) begin
                  state  <= LOCKED;
                  Locked <= 1'b1;
                end
              end else begin
                state       <= SEARCH;
                mc          <= '0;
                fill        <= '0;
                ResyncCount <= resync_inc;
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              DataOut   <= win;
              DataValid <= 1'b1;
            end
          end
          default: begin
            state  <= SEARCH;
            Locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_deser32b_align.sv
// tb_deser32b_align: scoreboard bench for deser32b_align; the bench acts as
// the serializer and queues every word it expects to see strobed out.
module tb_deser32b_align;

  localparam logic [31:0] SYNC = 32'hF0F0_A5A5;

  logic        CLKBit = 1'b0;
  logic        RSTn   = 1'b0;
  logic        SerIn  = 1'b0;
  logic        ReSync = 1'b0;
  logic [31:0] DataOut;
  logic        DataValid;
  logic        CLKWord;
  logic        Locked;
  logic [7:0]  ResyncCount;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  deser32b_align #(.SYNC_WORD(SYNC), .LOCK_CNT(4)) dut (
    .CLKBit      (CLKBit),
    .RSTn        (RSTn),
    .SerIn       (SerIn),
    .ReSync      (ReSync),
    .DataOut     (DataOut),
    .DataValid   (DataValid),
    .CLKWord     (CLKWord),
    .Locked      (Locked),
    .ResyncCount (ResyncCount)
  );

  // Bit clock.
  always #5 CLKBit = ~CLKBit;

  // Output monitor: every strobe must match the oldest queued word.
  always @(negedge CLKBit) begin
    if (DataValid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: DataOut=%h strobed, no word expected", DataOut);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (DataOut !== e) begin
          errors++;
          $display("FAIL dataout: got %h expected %h", DataOut, e);
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    SerIn = b;
    @(posedge CLKBit);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    ReSync = 1'b0;
    SerIn  = 1'b0;
    RSTn   = 1'b0;
    repeat (2) @(posedge CLKBit);
    #1 RSTn = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (100) begin
      SerIn = 1'($urandom);
      @(negedge CLKBit);
      checks++;
      if ({DataValid, Locked, CLKWord, ResyncCount, DataOut} !== {1'b0, 1'b0, 1'b1, 8'h00, 32'h0}) begin
        errors++;
        $display("FAIL reset_values: valid=%b locked=%b clkword=%b rcnt=%h data=%h, need 0 0 1 00 00000000",
                 DataValid, Locked, CLKWord, ResyncCount, DataOut);
      end
    end
    RSTn = 1'b1;
  endtask

  task automatic test_clean_lock();
    int p;
    do_reset();
    p = $urandom_range(0, 31);
    repeat (p) send_bit(1'($urandom));
    for (int i = 1; i <= 6; i++) begin
      if (i >= 5) exp_q.push_back(SYNC);
      send_word(SYNC);
      checks++;
      if (Locked !== 1'(i >= 4)) begin
        errors++;
        $display("FAIL clean_locked: after sync %0d Locked=%b required %b", i, Locked, 1'(i >= 4));
      end
    end
    exp_q.push_back(32'h1234_5678);
    send_word(32'h1234_5678);
    @(negedge CLKBit); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL clean_drain: %0d words never strobed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_false_start();
    do_reset();
    send_word(SYNC);
    repeat (7) send_bit(1'b0);
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) exp_q.push_back(SYNC);
      send_word(SYNC);
      checks++;
      if (Locked !== 1'(i >= 5)) begin
        errors++;
        $display("FAIL false_locked: after sync %0d Locked=%b required %b", i, Locked, 1'(i >= 5));
      end
      if (i == 1) begin
        checks++;
        if (ResyncCount !== 8'd1) begin
          errors++;
          $display("FAIL false_resync_count: got %0d required 1", ResyncCount);
        end
      end
    end
    exp_q.push_back(32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF);
    @(negedge CLKBit); #1;
    checks++;
    if (exp_q.size() != 0 || ResyncCount !== 8'd1) begin
      errors++;
      $display("FAIL false_drain: pending=%0d rcnt=%0d, required 0 and 1", exp_q.size(), ResyncCount);
      exp_q.delete();
    end
  endtask

  task automatic test_resync_locked();
    logic [31:0] w;
    logic [31:0] d;
    w = SYNC;
    do_reset();
    repeat (4) send_word(SYNC);
    checks++;
    if (Locked !== 1'b1) begin
      errors++;
      $display("FAIL resync_prelock: Locked=%b required 1", Locked);
    end
    for (int b = 31; b >= 1; b--) send_bit(w[b]);
    ReSync = 1'b1;
    send_bit(w[0]);
    ReSync = 1'b0;
    checks++;
    if ({DataValid, Locked, ResyncCount} !== {1'b0, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL resync_drop: valid=%b locked=%b rcnt=%0d, required 0 0 1", DataValid, Locked, ResyncCount);
    end
    for (int i = 1; i <= 4; i++) begin
      send_word(SYNC);
      checks++;
      if (Locked !== 1'(i == 4)) begin
        errors++;
        $display("FAIL resync_relock: after sync %0d Locked=%b required %b", i, Locked, 1'(i == 4));
      end
    end
    d = $urandom;
    exp_q.push_back(d);
    send_word(d);
    @(negedge CLKBit); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL resync_drain: %0d words never strobed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_phase_sweep();
    logic [31:0] d;
    for (int off = 0; off < 32; off++) begin
      do_reset();
      repeat (off) send_bit(1'($urandom));
      repeat (4) send_word(SYNC);
      for (int k = 0; k < 3; k++) begin
        d = $urandom;
        exp_q.push_back(d);
        send_word(d);
      end
      @(negedge CLKBit); #1;
      checks++;
      if (exp_q.size() != 0 || Locked !== 1'b1) begin
        errors++;
        $display("FAIL sweep_offset_%0d: pending=%0d locked=%b, required 0 and 1", off, exp_q.size(), Locked);
        exp_q.delete();
      end
    end
  endtask

  task automatic test_reset_midword();
    do_reset();
    ReSync = 1'b1;
    send_bit(1'b0);
    ReSync = 1'b0;
    repeat (4) send_word(SYNC);
    checks++;
    if (Locked !== 1'b1 || ResyncCount !== 8'd1) begin
      errors++;
      $display("FAIL midword_prelock: locked=%b rcnt=%0d, required 1 and 1", Locked, ResyncCount);
    end
    repeat (13) send_bit(1'($urandom));
    #2 RSTn = 1'b0;
    #1;
    checks++;
    if ({DataValid, Locked, CLKWord, ResyncCount, DataOut} !== {1'b0, 1'b0, 1'b1, 8'h00, 32'h0}) begin
      errors++;
      $display("FAIL midword_reset: valid=%b locked=%b clkword=%b rcnt=%h data=%h, need 0 0 1 00 00000000",
               DataValid, Locked, CLKWord, ResyncCount, DataOut);
    end
    repeat (40) send_bit(1'($urandom));
    RSTn = 1'b1;
  endtask

  task automatic test_saturation();
    logic [7:0] e;
    do_reset();
    for (int n = 1; n <= 300; n++) begin
      ReSync = 1'b1;
      send_bit(1'b0);
      ReSync = 1'b0;
      send_bit(1'b0);
      e = (n > 255) ? 8'd255 : 8'(n);
      checks++;
      if (ResyncCount !== e) begin
        errors++;
        $display("FAIL saturation: after %0d pulses ResyncCount=%0d required %0d", n, ResyncCount, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_false_start();
    test_resync_locked();
    test_phase_sweep();
    test_reset_midword();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
